// File: rtl/gs_butterfly_serial.sv
// Inverse-NTT Gentleman-Sande butterfly.
// a_out = (a + b) mod q and b_out = ((a - b) * w) mod q. The product is formed
// with a bit-serial interleaved shift-add multiplier, MSB of the twiddle first.
module gs_butterfly_serial #(
  parameter int unsigned Width = 16,
  parameter int unsigned Q     = 12289
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_in_i,
  input  logic [Width-1:0] b_in_i,
  input  logic [Width-1:0] w_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] a_out_o,
  output logic [Width-1:0] b_out_o
);

  localparam int unsigned    IdxW   = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [Width:0] QExt   = (Width + 1)'(Q);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           state_q;
  logic [Width-1:0] a_q;
  logic [Width-1:0] d_q;
  logic [Width-1:0] w_q;
  logic [Width-1:0] acc_q;
  logic [IdxW-1:0]  idx_q;

  logic [Width:0]   sum_raw;
  logic [Width-1:0] sum_res;
  logic [Width-1:0] diff_res;
  logic [Width:0]   dbl_raw;
  logic [Width:0]   dbl_red;
  logic [Width:0]   add_raw;
  logic [Width-1:0] step_res;

  // Operand preprocessing and one multiplier step; all values stay below 2q.
  always_comb begin
    sum_raw = {1'b0, a_in_i} + {1'b0, b_in_i};
    sum_res = (sum_raw >= QExt) ? Width'(sum_raw - QExt) : Width'(sum_raw);

    // Negative difference is wrapped by adding q before subtracting b.
    if (a_in_i >= b_in_i) begin
      diff_res = Width'({1'b0, a_in_i} - {1'b0, b_in_i});
    end else begin
      diff_res = Width'({1'b0, a_in_i} + QExt - {1'b0, b_in_i});
    end

    dbl_raw = {acc_q, 1'b0};
    dbl_red = (dbl_raw >= QExt) ? (dbl_raw - QExt) : dbl_raw;
    add_raw = w_q[idx_q] ? (dbl_red + {1'b0, d_q}) : dbl_red;
    step_res = (add_raw >= QExt) ? Width'(add_raw - QExt) : Width'(add_raw);
  end

  // Control FSM plus datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      d_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q     <= sum_res;
            d_q     <= diff_res;
            w_q     <= w_in_i;
            acc_q   <= '0;
            idx_q   <= IdxTop;
            state_q <= StMul;
          end
        end
        StMul: begin
          acc_q <= step_res;
          if (idx_q == '0) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; data are registers.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    a_out_o     = a_q;
    b_out_o     = acc_q;
  end

endmodule

// File: tb/tb_gs_butterfly_serial.sv
// Directed and randomised checks for gs_butterfly_serial at Width=16, q=12289.
module tb_gs_butterfly_serial;

  localparam int unsigned Width = 16;
  localparam int unsigned Q     = 12289;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a_in;
  logic [Width-1:0] b_in;
  logic [Width-1:0] w_in;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] a_out;
  logic [Width-1:0] b_out;

  int n_pass;
  int n_total;

  gs_butterfly_serial #(
    .Width(Width),
    .Q    (Q)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_in_i     (a_in),
    .b_in_i     (b_in),
    .w_in_i     (w_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .a_out_o    (a_out),
    .b_out_o    (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_a(input int a, input int b);
    return (a + b) % Q;
  endfunction

  function automatic int model_b(input int a, input int b, input int w);
    longint d;
    d = (longint'(a) - longint'(b) + longint'(Q)) % Q;
    return int'((d * longint'(w)) % Q);
  endfunction

  // One operation; stall = cycles out_ready is held low once the result appears.
  task automatic do_op(input string tag, input int a, input int b, input int w,
                       input int ea, input int eb, input int stall);
    int cnt;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    a_in      = Width'(a);
    b_in      = Width'(b);
    w_in      = Width'(w);
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, ".latency"}, 32'(cnt), 32'd16);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
    end
    check({tag, ".a_out"}, 32'(a_out), 32'(ea));
    check({tag, ".b_out"}, 32'(b_out), 32'(eb));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ra;
    int rb;
    int rw;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    w_in      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.a_out", 32'(a_out), 32'd0);
    check("rst.b_out", 32'(b_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    do_op("w1", 5, 3, 1, 8, 2, 0);
    do_op("subwrap", 3, 5, 1, 8, 12287, 0);
    do_op("w0", 7, 9, 0, 16, 0, 0);
    do_op("sumwrap", 12288, 1, 12288, 0, 2, 0);
    do_op("wmax", 2, 1, 65535, 3, 4090, 0);

    // Backpressure: operands offered during DONE must be ignored
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 16'd1000;
    b_in      = 16'd10;
    w_in      = 16'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
    end
    check("bp.out_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a_in     = Width'(c + 1);
      b_in     = Width'(c + 2);
      w_in     = Width'(c + 3);
      @(posedge clk);
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.a_out", 32'(a_out), 32'd1010);
      check("bp.b_out", 32'(b_out), 32'd6930);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.in_ready_after", 32'(in_ready), 32'd1);
    do_op("bp.next", 20, 30, 2, 50, 12269, 0);

    // Reset in the middle of MUL
    in_valid = 1'b1;
    a_in     = 16'd500;
    b_in     = 16'd100;
    w_in     = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.a_out", 32'(a_out), 32'd0);
    check("midrst.b_out", 32'(b_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("postrst", 100, 40, 3, 140, 180, 0);

    // Randomised legal triples with random result stalls
    for (int k = 0; k < 200; k++) begin
      ra = int'($urandom_range(0, Q - 1));
      rb = int'($urandom_range(0, Q - 1));
      rw = int'($urandom_range(0, 65535));
      do_op("rand", ra, rb, rw, model_a(ra, rb), model_b(ra, rb, rw),
            int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
